// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the default bit period.
package uart_pkg;

    // Default number of clk cycles per UART bit.
    localparam int CLKS_PER_BIT_DEFAULT = 87;

    // Receiver FSM states.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous UART line.
// Both flops reset to 1 so that a reset never looks like a start bit.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    // Shift the raw line through two flops; the second output is safe to use.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta     <= 1'b1;
            sync_out <= 1'b1;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Samples every bit at its middle using a cycle counter
// that is restarted at the start-bit midpoint, and reports good bytes and
// framing errors as single-cycle pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Rx_Serial,
    output logic [7:0] Rx_Parallel,
    output logic       Rx_Complete,
    output logic       Rx_Error,
    output logic       Rx_Busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);

    uart_rx_state_t   state;
    uart_rx_state_t   next_state;
    logic             rx_sync;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic             half_hit;
    logic             bit_done;
    logic             stop_good;
    logic             stop_bad;

    uart_rx_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (Rx_Serial),
        .sync_out (rx_sync)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decision from the synchronized line and the bit timers.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!rx_sync) begin
                    next_state = START;
                end
            end
            START: begin
                if (half_hit) begin
                    next_state = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_done && (bit_idx == 3'd7)) begin
                    next_state = STOP;
                end
            end
            STOP: begin
                if (bit_done) begin
                    next_state = rx_sync ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (rx_sync) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State-derived outputs and the timing/stop-bit strobes.
    always_comb begin
        Rx_Busy   = (state != IDLE);
        half_hit  = (state == START) && (clk_cnt == CNT_HALF);
        bit_done  = (clk_cnt == CNT_LAST);
        stop_good = (state == STOP) && bit_done && rx_sync;
        stop_bad  = (state == STOP) && bit_done && !rx_sync;
    end

    // Counters, data shift register, output byte and result pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_cnt     <= '0;
            bit_idx     <= 3'd0;
            shift_reg   <= 8'h00;
            Rx_Parallel <= 8'h00;
            Rx_Complete <= 1'b0;
            Rx_Error    <= 1'b0;
        end else begin
            Rx_Complete <= stop_good;
            Rx_Error    <= stop_bad;
            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    bit_idx <= 3'd0;
                end
                START: begin
                    if (half_hit) begin
                        clk_cnt <= '0;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        clk_cnt            <= '0;
                        shift_reg[bit_idx] <= rx_sync;
                        bit_idx            <= bit_idx + 3'd1;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        clk_cnt <= '0;
                        if (rx_sync) begin
                            Rx_Parallel <= shift_reg;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    clk_cnt <= '0;
                end
                default: begin
                    clk_cnt <= '0;
                    bit_idx <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 87, clk cycles per UART bit period; legal range 8..65535.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 Rx_Serial  input  1  asynchronous UART line, idle high; frame is 8N1.
REQ-005 Rx_Parallel  output  8  last correctly received byte, LSB first on the line.
REQ-006 Rx_Complete  output  1  one-cycle pulse when Rx_Parallel is updated with a good byte.
REQ-007 Rx_Error  output  1  one-cycle pulse on framing error, where the stop bit is sampled low.
REQ-008 Rx_Busy  output  1  high in every state except IDLE.

Function
REQ-009 Rx_Serial SHALL pass through a 2-flop synchronizer before any use; all sampling uses the synchronized value.
REQ-010 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-011 IDLE: on synchronized line = 0, go to START and clear the bit counter; otherwise stay.
REQ-012 START: count to (CLKS_PER_BIT-1)/2; re-sample there; if 0, go to DATA with counter cleared; if 1, treat as a glitch and return to IDLE with no output pulse.
REQ-013 DATA: after each CLKS_PER_BIT cycles (mid-bit), shift the sample into bit index 0..7, LSB first; after index 7, go to STOP.
REQ-014 STOP: after CLKS_PER_BIT cycles, sample the line.
REQ-015 STOP with sample = 1: load the shift register into Rx_Parallel, pulse Rx_Complete for exactly 1 cycle, and go to IDLE.
REQ-016 STOP with sample = 0: pulse Rx_Error for exactly 1 cycle, leave Rx_Parallel unchanged, and go to WAIT_HIGH.
REQ-017 WAIT_HIGH: stay until the synchronized line = 1, then go to IDLE; this covers line break or held-low.
REQ-018 Rx_Complete and Rx_Error SHALL never be high in the same cycle.
REQ-019 Rx_Parallel SHALL hold its value between Rx_Complete pulses.
REQ-020 Latency: Rx_Complete SHALL assert no later than round(9.5*CLKS_PER_BIT)+4 clk after the start-bit falling edge on Rx_Serial.
REQ-021 The cycle counter SHALL be $clog2(CLKS_PER_BIT) bits wide and never wrap inside a bit; the bit index counter SHALL be 3 bits wide.
REQ-022 Back-to-back frames (stop bit followed directly by the next start bit) SHALL be received without loss.
REQ-023 Tolerance: frames SHALL be received correctly with a transmitter bit period within +/-2% of CLKS_PER_BIT.

Reset
REQ-024 While rst = 1 at a clk edge: state = IDLE, counters = 0, shift register = 0, Rx_Parallel = 8'h00, Rx_Complete = 0, Rx_Error = 0, Rx_Busy = 0, synchronizer flops = 1.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no Rx_Complete or Rx_Error pulse.
REQ-026 After reset, reception SHALL resume only on the next falling edge of the synchronized line.

Structure
REQ-027 Package uart_pkg SHALL hold the state enum and the CLKS_PER_BIT default, shared with the transmitter.
REQ-028 Sub-module uart_rx_sync SHALL implement the 2-flop synchronizer with reset value 1.
REQ-029 Target size: 120-400 lines of RTL total.

Verification
REQ-030 CLKS_PER_BIT=16, send 0xA5 (8N1) -> Rx_Parallel=0xA5, exactly one Rx_Complete pulse within the REQ-020 bound, Rx_Error stays 0.
REQ-031 Send 0x00, 0xFF, 0x55 back-to-back with no idle gap -> three Rx_Complete pulses with values 0x00, 0xFF, 0x55 in order.
REQ-032 Send 0x3C with stop bit forced low, then hold the line low for 3 bit periods -> one Rx_Error pulse, Rx_Parallel unchanged, Rx_Busy high until the line returns high, then the next byte 0x81 is received correctly.
REQ-033 Drive a 3-cycle low glitch on an idle line -> no pulses, FSM back in IDLE within CLKS_PER_BIT/2+3 cycles.
REQ-034 Assert rst during DATA bit 4 of 0xC3 -> no pulses, outputs at reset values, and a following frame 0x5A is received correctly.
REQ-035 Send 0x96 with transmitter bit period 16*1.02 and 16*0.98 cycles -> 0x96 received correctly in both cases.
